adc_ep_packetizer: RTL and testbench
====================================

Name: adc_ep_packetizer

Overview:
- Sits between the ADC sample capture (already in the clk domain) and the USB device core's IN-endpoint transmit interface.
- Buffers 8-bit ADC samples in a FIFO and serves them to the core as IN packets of up to MAX_PKT bytes.
- Drives txcork, txval, txdat and txdat_len, and consumes txact, txpop and endpt.
- Replaces the single-sample holding register with real buffering and packet-length accounting.

Parameters:
DEPTH, 512, FIFO depth in bytes; power of two, at least 2*MAX_PKT
MAX_PKT, 64, maximum IN packet payload in bytes
EP_NUM, 1, endpoint number this block answers on

Ports:
clk  in  1  USB core clock; all logic on rising edge
rst  in  1  synchronous active-high reset
smp_val  in  1  one-cycle strobe: smp_dat holds a new sample
smp_dat  in  8  ADC sample
endpt  in  4  endpoint addressed by the current transaction
txact  in  1  IN transaction active (level)
txpop  in  1  core consumed the byte on txdat
txval  out  1  txdat holds a valid packet byte
txcork  out  1  1 = nothing to send (core NAKs); 0 = data ready
txdat  out  8  current packet byte
txdat_len  out  12  byte count of the packet offered or in progress
fill  out  log2(DEPTH)+1  bytes currently stored
smp_ovf  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset values: txval=0, txcork=1, txdat=0, txdat_len=0, fill=0, smp_ovf=0, pointers=0, state=IDLE. Reset applies immediately, including mid-packet; buffered data is discarded.
- Write side:
  - smp_val with fill<DEPTH: write at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - smp_val with fill==DEPTH: sample dropped, smp_ovf set to 1. smp_ovf clears only on rst.
- Fill accounting: write and pop in the same cycle leave fill unchanged. fill updates one cycle after the event.
- States: IDLE, SEND, DONE.
- IDLE:
  - txcork <= (fill==0); txdat_len <= min(fill, MAX_PKT), updated every cycle.
  - txdat <= mem[rd_ptr] (registered read); txval=0.
  - txact rising edge with endpt==EP_NUM and fill!=0: go to SEND, freeze txdat_len as pkt_len, cnt=0, txval=1 from the next cycle.
  - txact rising edge with endpt!=EP_NUM, or with fill==0: stay in IDLE, no pointer change.
- SEND:
  - txcork held 0, txdat_len frozen.
  - txpop with cnt<pkt_len: rd_ptr+1 (wrap), cnt+1, fill-1. txdat shows the next byte on the cycle after the pop.
  - cnt reaching pkt_len: txval=0, go to DONE.
  - txpop when txval=0: ignored.
  - txact falling before cnt==pkt_len (host abort/retry): go to IDLE. Already-popped bytes are consumed; unpopped bytes remain at the FIFO head.
- DONE: txval=0, txcork=1. Go to IDLE on txact low.
- Writes continue in every state; a write during SEND does not change the frozen txdat_len.
- No combinational path from any input to any output.

Optional Feature:
- Macro ADC_SEQ_HDR_EN.
- When defined:
  - Each packet starts with an 8-bit sequence byte; pkt_len = min(fill, MAX_PKT-1)+1.
  - The first txdat in SEND is seq; sample bytes follow. The header pop does not decrement fill.
  - seq increments once per packet that reaches DONE, wraps 255->0, and resets to 0.
  - An aborted packet does not increment seq.
- When undefined: no header; payload is samples only, as specified above.

Test Plan:
- Reset then idle: hold rst 2 cycles, no stimulus -> txcork=1, txval=0, txdat_len=0, fill=0, smp_ovf=0.
- Basic packet: write 10 samples 0x00..0x09, txact high with endpt=1, 10 pops -> txdat_len=10, bytes 0x00..0x09 in order, txval falls after 10th pop, fill=0, txcork=1 after txact low.
- Max-size split: write 100 bytes, two transactions -> first txdat_len=64 with bytes 0..63, second txdat_len=36 with bytes 64..99.
- Overflow and wrap: write DEPTH+3 samples with no reads -> fill=512, smp_ovf=1, last 3 dropped. Drain 8 packets -> 512 bytes in order; pointers wrapped; smp_ovf stays 1.
- Abort and wrong endpoint: txact with endpt=2 -> no pops accepted, fill unchanged. With 20 bytes stored and endpt=1, pop 5 then drop txact -> fill=15, next packet begins with byte 5, txdat_len=15.
- Simultaneous write/pop and mid-packet reset: write on the same cycle as a pop -> fill unchanged. Assert rst during SEND -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/adc_ep_packetizer.sv
// Buffers ADC samples in a FIFO and serves them to the USB core as IN packets of up to MAX_PKT.
// Define ADC_SEQ_HDR_EN to prefix every packet with an 8-bit sequence byte.
module adc_ep_packetizer #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned MAX_PKT = 64,
    parameter int unsigned EP_NUM  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   smp_val,
    input  logic [7:0]             smp_dat,
    input  logic [3:0]             endpt,
    input  logic                   txact,
    input  logic                   txpop,
    output logic                   txval,
    output logic                   txcork,
    output logic [7:0]             txdat,
    output logic [11:0]            txdat_len,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   smp_ovf
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] FullLvl = (AW+1)'(DEPTH);
    localparam logic [11:0] MaxLen  = 12'(MAX_PKT);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [AW:0]   fill_q, fill_d;
    logic [11:0]   cnt_q, cnt_d, len_q, len_d, offer_len, fill_ext;
    logic [7:0]    txdat_q, txdat_d;
    logic          txval_q, txval_d, txcork_q, txcork_d;
    logic          ovf_q, ovf_d, txact_q;
    logic          wr_en, pop_dec, act_rise, ep_hit;
`ifdef ADC_SEQ_HDR_EN
    logic [7:0]    seq_q, seq_d;
`endif

    assign wr_en    = smp_val && (fill_q != FullLvl);
    assign ovf_d    = ovf_q | (smp_val && (fill_q == FullLvl));
    assign act_rise = txact && !txact_q;
    assign ep_hit   = (endpt == 4'(EP_NUM));
    assign rd_nxt   = rd_ptr_q + AW'(1);

    always_comb begin
        fill_ext = 12'(fill_q);
`ifdef ADC_SEQ_HDR_EN
        offer_len = ((fill_ext > MaxLen - 12'd1) ? MaxLen - 12'd1 : fill_ext) + 12'd1;
`else
        offer_len = (fill_ext > MaxLen) ? MaxLen : fill_ext;
`endif
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        fill_d   = fill_q;
        if (wr_en && !pop_dec) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (!wr_en && pop_dec) begin
            fill_d = fill_q - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        txval_d  = txval_q;
        txcork_d = txcork_q;
        txdat_d  = txdat_q;
        pop_dec  = 1'b0;
`ifdef ADC_SEQ_HDR_EN
        seq_d    = seq_q;
`endif
        unique case (state_q)
            StIdle: begin
                txval_d  = 1'b0;
                txcork_d = (fill_q == '0);
                len_d    = (fill_q == '0) ? 12'd0 : offer_len;
                txdat_d  = (fill_q == '0) ? 8'd0 : mem_q[rd_ptr_q];
                cnt_d    = 12'd0;
                if (act_rise && ep_hit && (fill_q != '0)) begin
                    state_d  = StSend;
                    txval_d  = 1'b1;
                    txcork_d = 1'b0;
`ifdef ADC_SEQ_HDR_EN
                    txdat_d  = seq_q;
`endif
                end
            end
            StSend: begin
                if (txpop && txval_q && (cnt_q < len_q)) begin
                    cnt_d = cnt_q + 12'd1;
`ifdef ADC_SEQ_HDR_EN
                    // Header pop exposes the head sample without consuming it.
                    if (cnt_q == 12'd0) begin
                        txdat_d = mem_q[rd_ptr_q];
                    end else begin
                        rd_ptr_d = rd_nxt;
                        pop_dec  = 1'b1;
                        txdat_d  = mem_q[rd_nxt];
                    end
`else
                    rd_ptr_d = rd_nxt;
                    pop_dec  = 1'b1;
                    txdat_d  = mem_q[rd_nxt];
`endif
                end
                if (cnt_d == len_q) begin
                    state_d  = StDone;
                    txval_d  = 1'b0;
                    txcork_d = 1'b1;
`ifdef ADC_SEQ_HDR_EN
                    seq_d    = seq_q + 8'd1;
`endif
                end else if (!txact) begin
                    // Host abort: unpopped bytes stay at the FIFO head for the retry.
                    state_d  = StIdle;
                    txval_d  = 1'b0;
                    txcork_d = 1'b1;
                end
            end
            StDone: begin
                txval_d  = 1'b0;
                txcork_d = 1'b1;
                if (!txact) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= smp_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= 12'd0;
            len_q    <= 12'd0;
            txval_q  <= 1'b0;
            txcork_q <= 1'b1;
            txdat_q  <= 8'd0;
            ovf_q    <= 1'b0;
            txact_q  <= 1'b0;
`ifdef ADC_SEQ_HDR_EN
            seq_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            txval_q  <= txval_d;
            txcork_q <= txcork_d;
            txdat_q  <= txdat_d;
            ovf_q    <= ovf_d;
            txact_q  <= txact;
`ifdef ADC_SEQ_HDR_EN
            seq_q    <= seq_d;
`endif
        end
    end

    assign txval     = txval_q;
    assign txcork    = txcork_q;
    assign txdat     = txdat_q;
    assign txdat_len = len_q;
    assign fill      = fill_q;
    assign smp_ovf   = ovf_q;
endmodule

// File: tb/tb_adc_ep_packetizer.sv
// Self-checking bench for adc_ep_packetizer: directed steps plus random data against a queue model.
module tb_adc_ep_packetizer;
    localparam int unsigned DEPTH   = 512;
    localparam int unsigned MAX_PKT = 64;
    localparam int unsigned EP_NUM  = 1;

    logic        clk = 1'b0;
    logic        rst, smp_val, txact, txpop;
    logic [7:0]  smp_dat;
    logic [3:0]  endpt;
    logic        txval, txcork, smp_ovf;
    logic [7:0]  txdat;
    logic [11:0] txdat_len;
    logic [9:0]  fill;

    int n_assert = 0;
    int n_fail   = 0;

    byte unsigned q[$];
    bit           ovf_m;

    always #5 clk = ~clk;

    adc_ep_packetizer #(
        .DEPTH  (DEPTH),
        .MAX_PKT(MAX_PKT),
        .EP_NUM (EP_NUM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .smp_val  (smp_val),
        .smp_dat  (smp_dat),
        .endpt    (endpt),
        .txact    (txact),
        .txpop    (txpop),
        .txval    (txval),
        .txcork   (txcork),
        .txdat    (txdat),
        .txdat_len(txdat_len),
        .fill     (fill),
        .smp_ovf  (smp_ovf)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idle_len();
        return (q.size() > MAX_PKT) ? MAX_PKT : q.size();
    endfunction

    task automatic check_idle(input string tag);
        tick();
        tick();
        check({tag, "_fill"}, 32'(fill), q.size());
        check({tag, "_cork"}, 32'(txcork), 32'(q.size() == 0));
        check({tag, "_txval"}, 32'(txval), 0);
        check({tag, "_len"}, 32'(txdat_len), idle_len());
        check({tag, "_ovf"}, 32'(smp_ovf), 32'(ovf_m));
        if (q.size() != 0) check({tag, "_head"}, 32'(txdat), 32'(q[0]));
    endtask

    task automatic write_smp(input logic [7:0] d);
        smp_dat = d;
        smp_val = 1'b1;
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
        tick();
        smp_val = 1'b0;
    endtask

    task automatic write_burst(input int n, input bit rnd);
        for (int i = 0; i < n; i++) write_smp(rnd ? 8'($urandom) : 8'(i));
    endtask

    // n_abort < 0 runs the packet to completion, otherwise drops txact after n_abort pops.
    task automatic run_packet(input int n_abort, input bit gaps, input bit wr_mix);
        int exp_len, target, cnt, guard, sz;
        bit p;
        exp_len = idle_len();
        endpt   = 4'(EP_NUM);
        txact   = 1'b1;
        tick();
        check("send_txval", 32'(txval), 1);
        check("send_cork", 32'(txcork), 0);
        check("send_len", 32'(txdat_len), exp_len);
        target = (n_abort < 0) ? exp_len : n_abort;
        cnt    = 0;
        guard  = 0;
        while (cnt < target && guard < 1000) begin
            guard++;
            p = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (p) check("pkt_byte", 32'(txdat), 32'(q[0]));
            sz    = q.size();
            txpop = p;
            if (wr_mix && p) begin
                smp_dat = 8'($urandom);
                smp_val = 1'b1;
                if (q.size() < DEPTH) q.push_back(smp_dat);
                else ovf_m = 1'b1;
            end
            tick();
            txpop   = 1'b0;
            smp_val = 1'b0;
            if (p) begin
                void'(q.pop_front());
                cnt++;
            end
            if (wr_mix && p && sz < DEPTH) check("wr_pop_fill", 32'(fill), sz);
            check("run_fill", 32'(fill), q.size());
            check("frozen_len", 32'(txdat_len), exp_len);
            check("run_txval", 32'(txval), 32'(cnt < exp_len));
        end
        check("pkt_budget", cnt, target);
        if (n_abort < 0) check("done_cork", 32'(txcork), 1);
        txact = 1'b0;
        check_idle("post_pkt");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; smp_val = 1'b0; smp_dat = 8'd0; endpt = 4'd0; txact = 1'b0; txpop = 1'b0;
        ovf_m = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_txdat", 32'(txdat), 0);
        check_idle("reset");

        // Transaction with nothing buffered is ignored.
        endpt = 4'(EP_NUM); txact = 1'b1;
        tick();
        check("empty_txval", 32'(txval), 0);
        check("empty_cork", 32'(txcork), 1);
        txpop = 1'b1;
        tick();
        txpop = 1'b0; txact = 1'b0;
        check_idle("empty_act");

        write_burst(10, 1'b0);
        check_idle("basic_pre");
        run_packet(-1, 1'b0, 1'b0);

        write_burst(100, 1'b0);
        check_idle("split_pre");
        run_packet(-1, 1'b0, 1'b0);
        check("split_len2", 32'(txdat_len), 36);
        run_packet(-1, 1'b0, 1'b0);

        write_burst(20, 1'b0);
        check_idle("ep_pre");
        endpt = 4'd2; txact = 1'b1;
        tick();
        check("wrong_ep_txval", 32'(txval), 0);
        txpop = 1'b1;
        tick();
        txpop = 1'b0; txact = 1'b0;
        check_idle("wrong_ep");
        run_packet(5, 1'b0, 1'b0);
        check("abort_fill", 32'(fill), 15);
        check("abort_head", 32'(txdat), 5);
        run_packet(-1, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            write_burst(int'($urandom_range(1, 150)), 1'b1);
            check_idle("rnd_pre");
            run_packet(-1, 1'b1, 1'b1);
        end
        while (q.size() != 0) run_packet(-1, 1'b0, 1'b0);

        write_burst(DEPTH + 3, 1'b1);
        check_idle("ovf_pre");
        check("ovf_fill", 32'(fill), DEPTH);
        check("ovf_flag", 32'(smp_ovf), 1);
        for (int i = 0; i < 8; i++) run_packet(-1, 1'b0, 1'b0);
        check("drain_fill", 32'(fill), 0);
        check("drain_ovf", 32'(smp_ovf), 1);

        write_burst(10, 1'b1);
        check_idle("mid_rst_pre");
        endpt = 4'(EP_NUM); txact = 1'b1;
        tick();
        txpop = 1'b1;
        tick();
        tick();
        txpop = 1'b0; rst = 1'b1; txact = 1'b0;
        tick();
        check("mrst_txval", 32'(txval), 0);
        check("mrst_cork", 32'(txcork), 1);
        check("mrst_txdat", 32'(txdat), 0);
        check("mrst_len", 32'(txdat_len), 0);
        check("mrst_fill", 32'(fill), 0);
        check("mrst_ovf", 32'(smp_ovf), 0);
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        check_idle("post_rst");

        write_burst(70, 1'b1);
        check_idle("final_pre");
        run_packet(-1, 1'b1, 1'b1);
        run_packet(-1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
